// File: rtl/serial_mofn_detect_pkg.sv
// Shared defaults and types for the serial M-of-N fbibble checker.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package SerialTOFEDDefs_MofN;

    // Defaults reproduce the legacy fixed 2-of-5 TOFED detector.
    localparam int DEF_FBIBBLE_SIZE   = 5;
    localparam int DEF_ONESPERFBIBBLE = 2;
    localparam int DEF_ERRCNT_WIDTH   = 8;

    typedef logic bool_t;

    // ST_OVER means the current fbibble is already known to be bad (too many ones).
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OVER  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_mofn_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; inc at all-ones is absorbed (holds at maximum).
module tofed_sat_counter
    import SerialTOFEDDefs_MofN::*;
#(
    parameter int WIDTH = DEF_ERRCNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    bool_t at_max;
    assign at_max = (count == {WIDTH{1'b1}});

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_mofn_detect.sv
// Serial M-of-N checker: groups N qualified bits, flags fbibbles whose ones count != M, keeps an error tally (tally built only with SERIALTOFED_ERRCNT_EN).
// Latency: done/error/ones_count are registered, one cycle after the edge sampling the last bit; err_count follows done by one cycle.
// Backpressure: none; accepts a bit every in_valid cycle, gaps simply stall accumulation.
module serial_mofn_detect
    import SerialTOFEDDefs_MofN::*;
#(
    parameter int FBIBBLE_SIZE   = DEF_FBIBBLE_SIZE,
    parameter int ONESPERFBIBBLE = DEF_ONESPERFBIBBLE,
    parameter int ERRCNT_WIDTH   = DEF_ERRCNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic                                 in_bit,
    input  logic                                 clr_cnt,
    output logic                                 done,
    output logic                                 error,
    output logic [$clog2(FBIBBLE_SIZE+1)-1:0]    ones_count,
    output logic                                 over_early,
    output logic [ERRCNT_WIDTH-1:0]              err_count
);

    localparam int CW = $clog2(FBIBBLE_SIZE + 1);
    localparam int PW = $clog2(FBIBBLE_SIZE);
    localparam logic [CW-1:0] M_VAL    = CW'(ONESPERFBIBBLE);
    localparam logic [PW-1:0] LAST_POS = PW'(FBIBBLE_SIZE - 1);

    // Reject illegal configurations at elaboration.
    if (FBIBBLE_SIZE < 2 || FBIBBLE_SIZE > 32 ||
        ONESPERFBIBBLE < 0 || ONESPERFBIBBLE > FBIBBLE_SIZE ||
        ERRCNT_WIDTH < 1) begin : g_param_check
        $error("serial_mofn_detect: illegal FBIBBLE_SIZE/ONESPERFBIBBLE/ERRCNT_WIDTH");
    end

    state_t          state_q, state_d;
    logic [PW-1:0]   bit_pos_q, bit_pos_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic [CW-1:0]   ones_next;
    bool_t           last_bit;
    bool_t           done_d, error_d;
    logic [CW-1:0]   ones_count_d;

    // ones_q never exceeds N-1 before the final add, so ones_next fits in CW bits.
    assign ones_next = ones_q + CW'(in_bit);
    assign last_bit  = (bit_pos_q == LAST_POS);

    // Next-state and completion decode; a finished fbibble restarts in ST_ACCUM.
    always_comb begin
        state_d      = state_q;
        bit_pos_d    = bit_pos_q;
        ones_d       = ones_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        ones_count_d = '0;
        if (in_valid) begin
            if (last_bit) begin
                bit_pos_d    = '0;
                ones_d       = '0;
                state_d      = ST_ACCUM;
                done_d       = 1'b1;
                error_d      = (ones_next != M_VAL);
                ones_count_d = ones_next;
            end else begin
                bit_pos_d = bit_pos_q + PW'(1);
                ones_d    = ones_next;
                if (state_q == ST_ACCUM && ones_next > M_VAL) begin
                    state_d = ST_OVER;
                end
            end
        end
    end

    // State and registered result outputs; reset drops any partial fbibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            bit_pos_q  <= '0;
            ones_q     <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            ones_count <= '0;
        end else begin
            state_q    <= state_d;
            bit_pos_q  <= bit_pos_d;
            ones_q     <= ones_d;
            done       <= done_d;
            error      <= error_d;
            ones_count <= ones_count_d;
        end
    end

    assign over_early = (state_q == ST_OVER);

`ifdef SERIALTOFED_ERRCNT_EN
    tofed_sat_counter #(
        .WIDTH(ERRCNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done && error),
        .clr   (clr_cnt),
        .count (err_count)
    );
`else
    // Tally not built: port kept so wrappers are unchanged.
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_serial_mofn_detect.sv
// Scoreboard bench for serial_mofn_detect across three parameter sets.
// Latency: expectations carry the cycle on which done must appear.
// Backpressure: none; stimulus drives bits and idles on falling edges.
module tb_serial_mofn_detect;

    typedef struct {
        int err;
        int ones;
        int cnt;
        int due;
    } exp_t;

    logic clk;
    logic reset;
    logic clr_cnt;
    logic [2:0] vld, bitv, done_v, err_v, ovr_v;
    logic [2:0] oc5, oc4;
    logic [3:0] oc8;
    logic [1:0] ec5;
    logic [7:0] ec8, ec4;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    exp_t q[3][$];
    bit   pend[3];
    int   pcnt[3];

    serial_mofn_detect #(.FBIBBLE_SIZE(5), .ONESPERFBIBBLE(2), .ERRCNT_WIDTH(2)) dut5 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_bit(bitv[0]), .clr_cnt(clr_cnt),
        .done(done_v[0]), .error(err_v[0]), .ones_count(oc5), .over_early(ovr_v[0]), .err_count(ec5));

    serial_mofn_detect #(.FBIBBLE_SIZE(8), .ONESPERFBIBBLE(0), .ERRCNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_bit(bitv[1]), .clr_cnt(clr_cnt),
        .done(done_v[1]), .error(err_v[1]), .ones_count(oc8), .over_early(ovr_v[1]), .err_count(ec8));

    serial_mofn_detect #(.FBIBBLE_SIZE(4), .ONESPERFBIBBLE(4), .ERRCNT_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_bit(bitv[2]), .clr_cnt(clr_cnt),
        .done(done_v[2]), .error(err_v[2]), .ones_count(oc4), .over_early(ovr_v[2]), .err_count(ec4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ec(input int v);
`ifdef SERIALTOFED_ERRCNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_over(input int which, input int exp_over);
        if (exp_over >= 0)
            chk($sformatf("over_early[%0d]", which), int'(ovr_v[which]), exp_over);
    endtask

    // exp_over checks over_early as left by the previous bits, before this bit lands.
    task automatic send(input int which, input bit b, input int exp_over);
        @(negedge clk);
        chk_over(which, exp_over);
        vld  = 3'b000;
        bitv = 3'b000;
        vld[which]  = 1'b1;
        bitv[which] = b;
    endtask

    task automatic idle(input int which, input int exp_over);
        @(negedge clk);
        chk_over(which, exp_over);
        vld = 3'b000;
    endtask

    task automatic send_fb(input int which, input bit [7:0] bits, input int n);
        for (int i = 0; i < n; i++) send(which, bits[i], -1);
    endtask

    // Called in the same time step as the final bit's drive.
    task automatic expect_fb(input int which, input int err, input int ones, input int cnt);
        exp_t e;
        e.err  = err;
        e.ones = ones;
        e.cnt  = cnt;
        e.due  = cyc + 1;
        q[which].push_back(e);
    endtask

    // Monitor: pops an expectation per done pulse; err_count checked one cycle later.
    always @(negedge clk) begin
        int dn[3], er[3], oc[3], ecv[3];
        exp_t e;
        dn  = '{int'(done_v[0]), int'(done_v[1]), int'(done_v[2])};
        er  = '{int'(err_v[0]), int'(err_v[1]), int'(err_v[2])};
        oc  = '{int'(oc5), int'(oc8), int'(oc4)};
        ecv = '{int'(ec5), int'(ec8), int'(ec4)};
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                chk($sformatf("err_count[%0d]", i), ecv[i], pcnt[i]);
                pend[i] = 1'b0;
            end
            if (dn[i] != 0) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_done[%0d]", i), 1, 0);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("done_cycle[%0d]", i), cyc, e.due);
                    chk($sformatf("error[%0d]", i), er[i], e.err);
                    chk($sformatf("ones_count[%0d]", i), oc[i], e.ones);
                    pend[i] = 1'b1;
                    pcnt[i] = e.cnt;
                end
            end else begin
                chk($sformatf("idle_zero[%0d]", i), er[i] + oc[i], 0);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        clr_cnt = 1'b0;
        vld     = 3'b000;
        bitv    = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_error", int'(err_v[0]), 0);
        chk("rst_ones", int'(oc5), 0);
        chk("rst_over", int'(ovr_v[0]), 0);
        chk("rst_errcnt", int'(ec5), 0);

        // 1,1,0,0,0: good fbibble, never over
        send(0, 1, 0); send(0, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        expect_fb(0, 0, 2, 0);
        idle(0, 0); idle(0, 0);

        // 1,1,1,0,0: over after bit 3, drops with done
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 0, 1); send(0, 0, 1);
        expect_fb(0, 1, 3, ec(1));
        idle(0, 0); idle(0, 0);

        // 1,0,0,0,0 gapped
        send(0, 1, 0); idle(0, 0); send(0, 0, 0); idle(0, 0); send(0, 0, 0); idle(0, 0);
        send(0, 0, 0); idle(0, 0); send(0, 0, 0);
        expect_fb(0, 1, 1, ec(2));
        idle(0, 0); idle(0, 0);

        // partial fbibble discarded by reset (reset also clears the tally)
        send(0, 1, -1); send(0, 1, -1); send(0, 0, -1);
        @(negedge clk); vld = 3'b000; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        send(0, 1, 0); send(0, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        expect_fb(0, 0, 2, 0);
        idle(0, 0); idle(0, 0);

        // saturation of a 2-bit tally
        for (int k = 1; k <= 5; k++) begin
            send_fb(0, 8'h1F, 5);
            expect_fb(0, 1, 5, ec(k > 3 ? 3 : k));
            idle(0, 0); idle(0, -1);
        end

        // clear coincident with increment wins, then counting resumes
        send_fb(0, 8'h00, 5);
        expect_fb(0, 1, 0, 0);
        @(negedge clk); vld = 3'b000; clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        idle(0, -1);
        send_fb(0, 8'h01, 5);
        expect_fb(0, 1, 1, ec(1));
        idle(0, -1); idle(0, -1);

        // N=8, M=0
        send_fb(1, 8'h00, 8);
        expect_fb(1, 0, 0, 0);
        idle(1, 0); idle(1, 0);
        send(1, 0, 0); send(1, 1, 0); send(1, 0, 1); send(1, 0, 1);
        send(1, 0, 1); send(1, 0, 1); send(1, 0, 1); send(1, 0, 1);
        expect_fb(1, 1, 1, ec(1));
        idle(1, 0); idle(1, 0);

        // N=4, M=4
        send(2, 1, 0); send(2, 1, 0); send(2, 1, 0); send(2, 1, 0);
        expect_fb(2, 0, 4, 0);
        idle(2, 0); idle(2, 0);
        send_fb(2, 8'h0B, 4);
        expect_fb(2, 1, 3, ec(1));
        idle(2, 0); idle(2, 0);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("missing_done[%0d]", i), q[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
